// File: rtl/median_frame_sequencer.sv
// Frame-level controller for the binary median-filter datapath: streams a raster
// image into memory, runs the filter under a timeout and reports the wake result.
module median_frame_sequencer #(
    parameter int IMG_W       = 80,
    parameter int IMG_H       = 60,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_req,
    input  logic        pix_valid,
    input  logic        pix_data,
    output logic        pix_ready,
    output logic        mem_write,
    output logic [7:0]  mem_x,
    output logic [7:0]  mem_y,
    output logic        mem_data,
    output logic        filt_clr,
    output logic        filt_start,
    input  logic        filt_done,
    input  logic        wake_in,
    output logic        busy,
    output logic        frame_done,
    output logic        wake_out,
    output logic        timeout_err,
    output logic [15:0] frame_count
);

    localparam logic [7:0]  LAST_X    = 8'(IMG_W - 1);
    localparam logic [7:0]  LAST_Y    = 8'(IMG_H - 1);
    localparam logic [23:0] LAST_TICK = 24'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, SETTLE, START, FILTER, RESULT, REPORT
    } SeqState;

    SeqState     state;
    SeqState     nextState;
    logic        pending;
    logic [7:0]  xPos;
    logic [7:0]  yPos;
    logic [23:0] tickCount;
    logic        handshake;
    logic        lastPixel;
    logic        tickExpired;

    assign handshake   = pix_valid && (state == LOAD);
    assign lastPixel   = (xPos == LAST_X) && (yPos == LAST_Y);
    assign tickExpired = (tickCount == LAST_TICK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        pix_ready  = 1'b0;
        filt_clr   = 1'b0;
        filt_start = 1'b0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_req || pending) nextState = CLEAR;
            end
            CLEAR: begin
                filt_clr  = 1'b1;
                nextState = LOAD;
            end
            LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid && lastPixel) nextState = SETTLE;
            end
            SETTLE: begin
                nextState = START;
            end
            START: begin
                filt_start = 1'b1;
                nextState  = FILTER;
            end
            // A done arriving on the final tick still wins over the timeout
            FILTER: begin
                if (filt_done) nextState = RESULT;
                else if (tickExpired) nextState = REPORT;
            end
            RESULT: begin
                nextState = REPORT;
            end
            REPORT: begin
                frame_done = 1'b1;
                nextState  = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= 1'b0;
            xPos        <= 8'd0;
            yPos        <= 8'd0;
            tickCount   <= 24'd0;
            mem_write   <= 1'b0;
            mem_x       <= 8'd0;
            mem_y       <= 8'd0;
            mem_data    <= 1'b0;
            wake_out    <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            mem_write <= handshake;

            // Requests seen while busy coalesce into a single queued frame
            if (state == IDLE) pending <= 1'b0;
            else if (frame_req) pending <= 1'b1;

            if (state == CLEAR) begin
                xPos <= 8'd0;
                yPos <= 8'd0;
            end else if (handshake) begin
                if (xPos == LAST_X) begin
                    xPos <= 8'd0;
                    yPos <= yPos + 8'd1;
                end else begin
                    xPos <= xPos + 8'd1;
                end
            end

            if (handshake) begin
                mem_x    <= xPos;
                mem_y    <= yPos;
                mem_data <= pix_data;
            end

            if (state == START) tickCount <= 24'd0;
            else if (state == FILTER) tickCount <= tickCount + 24'd1;

            if (state == FILTER && !filt_done && tickExpired) begin
                timeout_err <= 1'b1;
                wake_out    <= 1'b0;
            end

            if (state == RESULT) wake_out <= wake_in;
            if (state == REPORT) frame_count <= frame_count + 16'd1;
        end
    end

endmodule
